gic_distributor_mp: RTL

- Parametrised multi-target interrupt distributor; next generation of the cluster's single-interface GIC-style controller.
- Adds four items:
  - a per-IRQ four-state lifecycle (inactive/pending/active/active+pending);
  - per-IRQ edge/level mode;
  - per-IRQ CPU target masks;
  - a per-CPU acknowledge/EOI handshake with individual priority masks.
- Sits between peripheral IRQ lines and the A78AE/R52 core IRQ inputs in cpu_cluster.

---
 rtl/gic_distributor_mp.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gic_distributor_mp.sv
// Multi-CPU GIC-style interrupt distributor; optional SWGEN register under GIC_DIST_SWGEN_EN.
// irq_out/ack/err/cfg_rdata registered (1 cycle); no backpressure, every request is answered next cycle.
module gic_distributor_mp #(
   parameter int NUM_IRQS = 64,
   parameter int NUM_CPUS = 4,
   parameter int PRI_W    = 8,
   parameter int ID_W     = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_IRQS-1:0]      irq_in,
   input  logic                     cfg_we,
   input  logic [7:0]               cfg_addr,
   input  logic [31:0]              cfg_wdata,
   output logic [31:0]              cfg_rdata,
   output logic [NUM_CPUS-1:0]      irq_out,
   input  logic [NUM_CPUS-1:0]      ack_req,
   output logic [NUM_CPUS-1:0]      ack_vld,
   output logic [NUM_CPUS*ID_W-1:0] ack_id,
   input  logic [NUM_CPUS-1:0]      eoi_req,
   input  logic [NUM_CPUS*ID_W-1:0] eoi_id,
   output logic                     err_pulse
);

   localparam logic [ID_W-1:0] SPURIOUS = '1;

   logic [NUM_IRQS-1:0] pend_q, pend_d, act_q, act_d;
   logic [NUM_IRQS-1:0] en_q, en_d, edge_q, edge_d, irq_dly_q, irq_dly_d;
   logic [PRI_W-1:0]    prio_q [NUM_IRQS];
   logic [PRI_W-1:0]    prio_d [NUM_IRQS];
   logic [NUM_CPUS-1:0] tgt_q  [NUM_IRQS];
   logic [NUM_CPUS-1:0] tgt_d  [NUM_IRQS];
   logic                ctrl_en_q, ctrl_en_d;
   logic [PRI_W-1:0]    pmr_q  [NUM_CPUS];
   logic [PRI_W-1:0]    pmr_d  [NUM_CPUS];
   logic [NUM_CPUS-1:0] busy_q, busy_d;
   logic [ID_W-1:0]     own_q  [NUM_CPUS];
   logic [ID_W-1:0]     own_d  [NUM_CPUS];

   logic [NUM_CPUS-1:0]      irq_out_q, irq_out_d, ack_vld_q, ack_vld_d;
   logic [NUM_CPUS*ID_W-1:0] ack_id_q, ack_id_d;
   logic [31:0]              rdata_q, rdata_d;
   logic                     err_q, err_d;

   logic [NUM_CPUS-1:0] cand_vld;
   logic [ID_W-1:0]     cand_id [NUM_CPUS];

   logic [1:0] region;
   logic [5:0] idx;
   logic       unused_wdata;

   assign region       = cfg_addr[7:6];
   assign idx          = cfg_addr[5:0];
   assign unused_wdata = ^cfg_wdata;

   // Per-CPU candidate: ascending scan with strict compare gives lowest ID on ties.
   always_comb begin
      logic [PRI_W-1:0] best;
      logic             found;
      best  = '1;
      found = 1'b0;
      for (int c = 0; c < NUM_CPUS; c++) begin
         best       = '1;
         found      = 1'b0;
         cand_id[c] = SPURIOUS;
         for (int i = 0; i < NUM_IRQS; i++) begin
            if (en_q[i] && pend_q[i] && tgt_q[i][c] && (prio_q[i] < pmr_q[c])) begin
               if (!found || (prio_q[i] < best)) begin
                  found      = 1'b1;
                  best       = prio_q[i];
                  cand_id[c] = ID_W'(i);
               end
            end
         end
         cand_vld[c] = found && ctrl_en_q && !busy_q[c];
      end
   end

   always_comb begin
      logic [ID_W-1:0]     eid;
      logic                hit;
      logic [NUM_IRQS-1:0] taken;
      pend_d    = pend_q;
      act_d     = act_q;
      en_d      = en_q;
      edge_d    = edge_q;
      prio_d    = prio_q;
      tgt_d     = tgt_q;
      ctrl_en_d = ctrl_en_q;
      pmr_d     = pmr_q;
      busy_d    = busy_q;
      own_d     = own_q;
      irq_dly_d = irq_in;
      irq_out_d = cand_vld;
      ack_vld_d = ack_req;
      ack_id_d  = {NUM_CPUS{SPURIOUS}};
      err_d     = 1'b0;
      rdata_d   = 32'd0;
      eid       = '0;
      hit       = 1'b0;
      taken     = '0;

      // EOI first so a same-cycle edge or level re-pend lands after the release.
      for (int c = 0; c < NUM_CPUS; c++) begin
         if (eoi_req[c]) begin
            eid = eoi_id[c*ID_W +: ID_W];
            hit = 1'b0;
            for (int i = 0; i < NUM_IRQS; i++) begin
               if (ID_W'(i) == eid && act_q[i]) hit = 1'b1;
            end
            if (hit && busy_q[c] && own_q[c] == eid) begin
               busy_d[c] = 1'b0;
               for (int i = 0; i < NUM_IRQS; i++) begin
                  if (ID_W'(i) == eid) act_d[i] = 1'b0;
               end
            end else begin
               err_d = 1'b1;
            end
         end
      end

      // Acks resolve against pre-write config; lower CPU index claims an ID first.
      for (int c = 0; c < NUM_CPUS; c++) begin
         if (ack_req[c] && cand_vld[c]) begin
            for (int i = 0; i < NUM_IRQS; i++) begin
               if (ID_W'(i) == cand_id[c] && !taken[i]) begin
                  taken[i]                  = 1'b1;
                  ack_id_d[c*ID_W +: ID_W] = cand_id[c];
                  busy_d[c]                 = 1'b1;
                  own_d[c]                  = cand_id[c];
                  if (edge_q[i] || !act_q[i]) pend_d[i] = 1'b0;
                  act_d[i] = 1'b1;
               end
            end
         end
      end

      for (int i = 0; i < NUM_IRQS; i++) begin
         if (edge_q[i]) begin
            if (irq_in[i] && !irq_dly_q[i]) pend_d[i] = 1'b1;
         end else if (!act_d[i]) begin
            pend_d[i] = irq_in[i];
         end
      end

      if (cfg_we) begin
         case (region)
            2'd0: begin
               if (idx == 6'd0) ctrl_en_d = cfg_wdata[0];
               for (int c = 0; c < NUM_CPUS; c++) begin
                  if (idx == 6'(c + 1)) pmr_d[c] = cfg_wdata[PRI_W-1:0];
               end
`ifdef GIC_DIST_SWGEN_EN
               if (idx == 6'd63) begin
                  for (int i = 0; i < NUM_IRQS; i++) begin
                     if (ID_W'(i) == cfg_wdata[ID_W-1:0]) pend_d[i] = 1'b1;
                  end
               end
`endif
            end
            2'd1: for (int i = 0; i < NUM_IRQS; i++) begin
               if (idx == 6'(i)) prio_d[i] = cfg_wdata[PRI_W-1:0];
            end
            2'd2: for (int i = 0; i < NUM_IRQS; i++) begin
               if (idx == 6'(i)) tgt_d[i] = cfg_wdata[NUM_CPUS-1:0];
            end
            default: for (int i = 0; i < NUM_IRQS; i++) begin
               if (idx == 6'(i)) begin
                  en_d[i]   = cfg_wdata[0];
                  edge_d[i] = cfg_wdata[1];
               end
            end
         endcase
      end

      case (region)
         2'd0: begin
            if (idx == 6'd0) rdata_d = {31'd0, ctrl_en_q};
            for (int c = 0; c < NUM_CPUS; c++) begin
               if (idx == 6'(c + 1)) rdata_d = 32'(pmr_q[c]);
            end
         end
         2'd1: for (int i = 0; i < NUM_IRQS; i++) begin
            if (idx == 6'(i)) rdata_d = 32'(prio_q[i]);
         end
         2'd2: for (int i = 0; i < NUM_IRQS; i++) begin
            if (idx == 6'(i)) rdata_d = 32'(tgt_q[i]);
         end
         default: for (int i = 0; i < NUM_IRQS; i++) begin
            if (idx == 6'(i)) rdata_d = {29'd0, pend_q[i], edge_q[i], en_q[i]};
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q    <= '0;
         act_q     <= '0;
         en_q      <= '0;
         edge_q    <= '0;
         irq_dly_q <= '0;
         ctrl_en_q <= 1'b0;
         busy_q    <= '0;
         irq_out_q <= '0;
         ack_vld_q <= '0;
         ack_id_q  <= {NUM_CPUS{SPURIOUS}};
         rdata_q   <= 32'd0;
         err_q     <= 1'b0;
         for (int i = 0; i < NUM_IRQS; i++) begin
            prio_q[i] <= '0;
            tgt_q[i]  <= '0;
         end
         for (int c = 0; c < NUM_CPUS; c++) begin
            pmr_q[c] <= '1;
            own_q[c] <= SPURIOUS;
         end
      end else begin
         pend_q    <= pend_d;
         act_q     <= act_d;
         en_q      <= en_d;
         edge_q    <= edge_d;
         irq_dly_q <= irq_dly_d;
         ctrl_en_q <= ctrl_en_d;
         busy_q    <= busy_d;
         irq_out_q <= irq_out_d;
         ack_vld_q <= ack_vld_d;
         ack_id_q  <= ack_id_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         prio_q    <= prio_d;
         tgt_q     <= tgt_d;
         pmr_q     <= pmr_d;
         own_q     <= own_d;
      end
   end

   assign cfg_rdata = rdata_q;
   assign irq_out   = irq_out_q;
   assign ack_vld   = ack_vld_q;
   assign ack_id    = ack_id_q;
   assign err_pulse = err_q;

endmodule
